hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Central pipeline sequencer for the 5-stage core. Drives the PC enable plus the write-enable (xW)
//  and flush (xRST) controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. Handles i/d-cache
//  waits, load-use stalls, jump and branch flushes, and halt. Keeps saturating stall/flush counters.
// PARAMETERS
//  CNT_W    16   width of stall_cnt / flush_cnt
//  REG_W    5    register-select width
// PORTS
//  CLK          in   1      clock, rising edge
//  RST          in   1      one clock; reset is asynchronous and active-high
//  ihit         in   1      fetch data valid this cycle
//  dmem_req     in   1      MEM stage holds load or store
//  dhit         in   1      data access completes this cycle
//  ex_memread   in   1      EX stage instr is a load
//  ex_wsel      in   REG_W  EX stage destination register
//  id_rsel1     in   REG_W  ID stage rs
//  id_rsel2     in   REG_W  ID stage rt
//  id_uses_rt   in   1      ID instr reads rt
//  id_jump      in   1      J/JAL/JR decoded in ID
//  ex_br_taken  in   1      branch resolved taken in EX
//  mem_halt     in   1      HALT instr in MEM
//  pcW          out  1      PC update enable
//  ifW,idW,exW,memW   out 1 each  pipeline-register write enables (IF/ID, ID/EX, EX/MEM, MEM/WB)
//  ifRST,idRST,exRST  out 1 each  load-zero (bubble) when paired xW=1
//  halted       out  1      core halted (registered)
//  stall_cnt    out  CNT_W  cycles with pcW=0 outside HALTED, saturating
//  flush_cnt    out  CNT_W  count of jump/branch flush events, saturating
// BEHAVIOUR
//  State: RUN, DWAIT, HALTED (2-bit reg). Reset: state=RUN, halted=0, both counters=0, async.
//  Controls are combinational from state+inputs. Default in RUN: all xW=1, all xRST=0, pcW=1.
//  Priority, highest first, first match wins:
//   1 HALTED: all xW=0, pcW=0, xRST=0. Sticky until RST.
//   2 dmem_req&!dhit: freeze; all xW=0, pcW=0. RUN->DWAIT (DWAIT stays while !dhit).
//   3 mem_halt (memory done): memW=1, all other xW=0, pcW=0; next state HALTED, halted<=1.
//   4 ex_br_taken: pcW=1 (target loaded), ifW=idW=1 with ifRST=idRST=1; exW=memW=1. flush_cnt++.
//     Overrides load-use and jump (both squashed instrs are wrong-path).
//   5 load-use: ex_memread & ex_wsel!=0 & (ex_wsel==id_rsel1 | id_uses_rt&ex_wsel==id_rsel2):
//     pcW=0, ifW=0 (IF/ID holds), idW=1 idRST=1 (bubble), exW=memW=1. Exactly 1 bubble.
//   6 id_jump: pcW=1, ifW=1 ifRST=1, rest advance. flush_cnt++. If !ihit also true, still redirect.
//   7 !ihit: pcW=0, ifW=1 ifRST=1 (bubble into ID), downstream advance.
//  DWAIT->RUN on the cycle dhit=1; that cycle evaluates rules 3-7 as in RUN.
//  Simultaneous dmem wait + branch/jump: freeze wins; redirect taken once dhit (inputs held stable).
//  ex_wsel==0 never triggers load-use. Counters saturate at all-ones, no wrap.
//  stall_cnt increments every cycle pcW=0 and state!=HALTED (incl. the halt cycle).
//  RST mid-stall/mid-halt: immediate RUN, counters cleared, outputs to RUN defaults.
// TESTING
//  Load r3 in EX, ID reads rs=r3 -> one cycle pcW=0, ifW=0, idRST=1; next cycle all advance; stall_cnt=1.
//  Same with ex_wsel=0 -> no stall, stall_cnt stays 0.
//  dmem_req=1, dhit=0 for 4 cycles then 1 -> all xW=0 4 cycles in DWAIT, RUN after; stall_cnt=4.
//  ex_br_taken & load-use same cycle -> pcW=1, ifRST=idRST=1, flush_cnt=1; no load-use hold.
//  mem_halt with dhit -> memW=1 only; next cycle halted=1, all xW=0 until RST.
//  RST asserted in DWAIT -> state RUN, counters 0, pcW=1 same cycle.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//    Bundles the pipeline-status inputs and the sequencing controls exchanged
//    between the datapath and the hazard controller.
//    master : datapath side (drives hazard status, receives controls)
//    slave  : hazard_ctrl side (receives status, drives controls)
//    Status : ihit, dmem_req, dhit, ex_memread, ex_wsel, id_rsel1, id_rsel2,
//             id_uses_rt, id_jump, ex_br_taken, mem_halt
//    Control: pcW, ifW, idW, exW, memW, ifRST, idRST, exRST, halted,
//             stall_cnt, flush_cnt
interface hazard_ctrl_if #(
   parameter int CNT_W = 16,
   parameter int REG_W = 5
);
   logic             ihit;
   logic             dmem_req;
   logic             dhit;
   logic             ex_memread;
   logic [REG_W-1:0] ex_wsel;
   logic [REG_W-1:0] id_rsel1;
   logic [REG_W-1:0] id_rsel2;
   logic             id_uses_rt;
   logic             id_jump;
   logic             ex_br_taken;
   logic             mem_halt;

   logic             pcW;
   logic             ifW;
   logic             idW;
   logic             exW;
   logic             memW;
   logic             ifRST;
   logic             idRST;
   logic             exRST;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output ihit, dmem_req, dhit, ex_memread, ex_wsel, id_rsel1, id_rsel2,
             id_uses_rt, id_jump, ex_br_taken, mem_halt,
      input  pcW, ifW, idW, exW, memW, ifRST, idRST, exRST, halted,
             stall_cnt, flush_cnt
   );

   modport slave (
      input  ihit, dmem_req, dhit, ex_memread, ex_wsel, id_rsel1, id_rsel2,
             id_uses_rt, id_jump, ex_br_taken, mem_halt,
      output pcW, ifW, idW, exW, memW, ifRST, idRST, exRST, halted,
             stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//    Central sequencer for the 5-stage pipeline. Produces the PC enable and the
//    write-enable / bubble controls of the IF/ID, ID/EX, EX/MEM and MEM/WB
//    registers from the current state and the hazard status, handling cache
//    waits, load-use stalls, jump/branch redirects and halt. Keeps saturating
//    stall and flush counters.
//    Ports:
//       CLK  : clock, rising edge
//       RST  : asynchronous active-high reset
//       bus  : hazard_ctrl_if.slave (status in, controls/counters out)
module hazard_ctrl #(
   parameter int CNT_W = 16,
   parameter int REG_W = 5
) (
   input logic          CLK,
   input logic          RST,
   hazard_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DWAIT  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t           state;
   logic             halted_r;
   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] flush_cnt_r;

   logic             dwait_hold;
   logic             load_use;
   logic             flush_evt;
   logic             pc_w, if_w, id_w, ex_w, mem_w;
   logic             if_rst, id_rst;

   // In DWAIT only dhit releases the freeze; from RUN a new access must be pending.
   assign dwait_hold = (state == DWAIT) ? !bus.dhit : (bus.dmem_req && !bus.dhit);

   // r0 is hardwired zero, so a load targeting it never creates a dependency.
   assign load_use = bus.ex_memread && (bus.ex_wsel != '0) &&
                     ((bus.ex_wsel == bus.id_rsel1) ||
                      (bus.id_uses_rt && (bus.ex_wsel == bus.id_rsel2)));

   always_comb begin
      pc_w      = 1'b1;
      if_w      = 1'b1;
      id_w      = 1'b1;
      ex_w      = 1'b1;
      mem_w     = 1'b1;
      if_rst    = 1'b0;
      id_rst    = 1'b0;
      flush_evt = 1'b0;
      if (RST) begin
         // Controls show the RUN defaults while reset is held.
      end else if (state == HALTED || dwait_hold) begin
         pc_w  = 1'b0;
         if_w  = 1'b0;
         id_w  = 1'b0;
         ex_w  = 1'b0;
         mem_w = 1'b0;
      end else if (bus.mem_halt) begin
         // Let the HALT retire into MEM/WB, freeze everything behind it.
         pc_w = 1'b0;
         if_w = 1'b0;
         id_w = 1'b0;
         ex_w = 1'b0;
      end else if (bus.ex_br_taken) begin
         // Both younger instructions are wrong-path: squash IF/ID and ID/EX.
         if_rst    = 1'b1;
         id_rst    = 1'b1;
         flush_evt = 1'b1;
      end else if (load_use) begin
         pc_w   = 1'b0;
         if_w   = 1'b0;
         id_rst = 1'b1;
      end else if (bus.id_jump) begin
         // Redirect even on an i-cache miss; the fetched slot is dropped anyway.
         if_rst    = 1'b1;
         flush_evt = 1'b1;
      end else if (!bus.ihit) begin
         pc_w   = 1'b0;
         if_rst = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= RUN;
         halted_r    <= 1'b0;
         stall_cnt_r <= '0;
         flush_cnt_r <= '0;
      end else if (state != HALTED) begin
         if (dwait_hold) begin
            state <= DWAIT;
         end else if (bus.mem_halt) begin
            state    <= HALTED;
            halted_r <= 1'b1;
         end else begin
            state <= RUN;
         end
         if (!pc_w && (stall_cnt_r != '1)) begin
            stall_cnt_r <= stall_cnt_r + 1'b1;
         end
         if (flush_evt && (flush_cnt_r != '1)) begin
            flush_cnt_r <= flush_cnt_r + 1'b1;
         end
      end
   end

   assign bus.pcW       = pc_w;
   assign bus.ifW       = if_w;
   assign bus.idW       = id_w;
   assign bus.exW       = ex_w;
   assign bus.memW      = mem_w;
   assign bus.ifRST     = if_rst;
   assign bus.idRST     = id_rst;
   assign bus.exRST     = 1'b0;
   assign bus.halted    = halted_r;
   assign bus.stall_cnt = stall_cnt_r;
   assign bus.flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//    Directed scenarios followed by randomized traffic, every cycle compared
//    against a rule-level reference model of the sequencer. Counters are kept
//    narrow here so saturation is reached during the random run.
module tb_hazard_ctrl;

   localparam int CNT_W = 4;
   localparam int REG_W = 5;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic CLK = 1'b0;
   logic RST = 1'b0;

   always #5 CLK = ~CLK;

   hazard_ctrl_if #(.CNT_W(CNT_W), .REG_W(REG_W)) bus ();

   hazard_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference model state
   bit m_halted;
   bit m_wait;
   int m_stall;
   int m_flush;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected {flush_event, pcW, ifW, idW, exW, memW, ifRST, idRST, exRST}
   function automatic logic [8:0] model_ctrl();
      logic lu;
      logic waiting;
      waiting = m_wait ? !bus.dhit : (bus.dmem_req && !bus.dhit);
      lu = bus.ex_memread && bus.ex_wsel != 0 &&
           (bus.ex_wsel == bus.id_rsel1 || (bus.id_uses_rt && bus.ex_wsel == bus.id_rsel2));
      if (m_halted || waiting) return 9'b0_00000_000;
      if (bus.mem_halt)        return 9'b0_00001_000;
      if (bus.ex_br_taken)     return 9'b1_11111_110;
      if (lu)                  return 9'b0_00111_010;
      if (bus.id_jump)         return 9'b1_11111_100;
      if (!bus.ihit)           return 9'b0_01111_100;
      return 9'b0_11111_000;
   endfunction

   task automatic idle();
      bus.ihit = 1'b1;  bus.dmem_req = 1'b0;  bus.dhit = 1'b0;
      bus.ex_memread = 1'b0;  bus.ex_wsel = '0;  bus.id_rsel1 = '0;  bus.id_rsel2 = '0;
      bus.id_uses_rt = 1'b0;  bus.id_jump = 1'b0;  bus.ex_br_taken = 1'b0;  bus.mem_halt = 1'b0;
   endtask

   // Called at a falling edge with inputs already applied; checks, clocks, updates the model.
   task automatic step();
      logic [8:0] e;
      logic waiting;
      e = model_ctrl();
      waiting = m_wait ? !bus.dhit : (bus.dmem_req && !bus.dhit);
      #1;
      check("ctrl", 32'({bus.pcW, bus.ifW, bus.idW, bus.exW, bus.memW,
                         bus.ifRST, bus.idRST, bus.exRST}), 32'(e[7:0]));
      check("halted", 32'(bus.halted), 32'(m_halted));
      check("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
      check("flush_cnt", 32'(bus.flush_cnt), 32'(m_flush));
      @(posedge CLK);
      if (!m_halted) begin
         if (!e[7] && m_stall < MAXC) m_stall++;
         if (e[8] && m_flush < MAXC) m_flush++;
         if (waiting) m_wait = 1'b1;
         else begin
            m_wait = 1'b0;
            if (bus.mem_halt) m_halted = 1'b1;
         end
      end
      @(negedge CLK);
   endtask

   // Asynchronous reset asserted mid-cycle; RUN defaults must appear immediately.
   task automatic do_reset();
      RST = 1'b1;
      #1;
      check("rst_ctrl", 32'({bus.pcW, bus.ifW, bus.idW, bus.exW, bus.memW,
                             bus.ifRST, bus.idRST, bus.exRST}), 32'h0F8);
      check("rst_halted", 32'(bus.halted), 32'd0);
      check("rst_stall", 32'(bus.stall_cnt), 32'd0);
      check("rst_flush", 32'(bus.flush_cnt), 32'd0);
      m_halted = 1'b0;  m_wait = 1'b0;  m_stall = 0;  m_flush = 0;
      @(negedge CLK);
      RST = 1'b0;
      idle();
   endtask

   initial begin
      idle();
      @(negedge CLK);
      do_reset();
      $display("reset: pcW=%0b stall=%0d flush=%0d", bus.pcW, bus.stall_cnt, bus.flush_cnt);

      // Load-use on rs
      bus.ex_memread = 1'b1;  bus.ex_wsel = 5'd3;  bus.id_rsel1 = 5'd3;
      step();
      idle();
      step();
      check("lu_stall", 32'(bus.stall_cnt), 32'd1);
      $display("load-use r3: stall=%0d", bus.stall_cnt);

      // Load into r0 never stalls
      do_reset();
      bus.ex_memread = 1'b1;  bus.ex_wsel = '0;  bus.id_rsel1 = '0;  bus.id_rsel2 = '0;
      bus.id_uses_rt = 1'b1;
      step();
      idle();
      step();
      check("r0_stall", 32'(bus.stall_cnt), 32'd0);
      $display("load-use r0: stall=%0d", bus.stall_cnt);

      // Four-cycle d-cache wait
      do_reset();
      bus.dmem_req = 1'b1;
      for (int i = 0; i < 4; i++) step();
      bus.dhit = 1'b1;
      step();
      idle();
      step();
      check("dwait_stall", 32'(bus.stall_cnt), 32'd4);
      $display("dcache wait x4: stall=%0d", bus.stall_cnt);

      // Branch overrides a simultaneous load-use
      do_reset();
      bus.ex_br_taken = 1'b1;  bus.ex_memread = 1'b1;  bus.ex_wsel = 5'd7;  bus.id_rsel1 = 5'd7;
      #1;
      check("br_pcW", 32'(bus.pcW), 32'd1);
      check("br_ifW", 32'(bus.ifW), 32'd1);
      step();
      idle();
      step();
      check("br_flush", 32'(bus.flush_cnt), 32'd1);
      $display("branch+load-use: flush=%0d stall=%0d", bus.flush_cnt, bus.stall_cnt);

      // Halt retiring with its data access complete
      do_reset();
      bus.mem_halt = 1'b1;  bus.dmem_req = 1'b1;  bus.dhit = 1'b1;
      step();
      idle();
      for (int i = 0; i < 3; i++) step();
      check("halt_sticky", 32'(bus.halted), 32'd1);
      $display("halt: halted=%0b stall=%0d", bus.halted, bus.stall_cnt);

      // Reset while waiting on the d-cache
      do_reset();
      bus.dmem_req = 1'b1;
      step();
      step();
      do_reset();
      $display("reset in DWAIT: pcW=%0b stall=%0d", bus.pcW, bus.stall_cnt);

      // Randomized traffic
      for (int n = 0; n < 800; n++) begin
         if (m_halted && $urandom_range(0, 3) == 0) begin
            do_reset();
         end else begin
            bus.ihit        = ($urandom_range(0, 9) < 8);
            bus.dmem_req    = m_wait ? 1'b1 : ($urandom_range(0, 9) < 3);
            bus.dhit        = ($urandom_range(0, 9) < 6);
            bus.ex_memread  = ($urandom_range(0, 9) < 3);
            bus.ex_wsel     = 5'($urandom_range(0, 3));
            bus.id_rsel1    = 5'($urandom_range(0, 3));
            bus.id_rsel2    = 5'($urandom_range(0, 3));
            bus.id_uses_rt  = 1'($urandom_range(0, 1));
            bus.id_jump     = ($urandom_range(0, 19) < 3);
            bus.ex_br_taken = ($urandom_range(0, 19) < 3);
            bus.mem_halt    = ($urandom_range(0, 99) < 2);
            step();
         end
      end
      $display("random: stall=%0d flush=%0d halted=%0b", bus.stall_cnt, bus.flush_cnt, bus.halted);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
